// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Divider datapath is included only when MDU_DIV_EN is defined.
package mdu_pkg;

    typedef enum logic [1:0] {
        MUL   = 2'd0,
        MULHU = 2'd1,
        DIVU  = 2'd2,
        REMU  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    // Widest operand supported by the divide-by-zero quotient constant.
    localparam int unsigned MAX_WIDTH = 64;
    localparam logic [MAX_WIDTH-1:0] DIV0_QUOT = '1;

endpackage

// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one bit per cycle.
// Define MDU_DIV_EN to build the divider; otherwise DIVU/REMU return 0 immediately.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_e               state_q, state_d;
    op_e                  op_q;
    logic [WIDTH-1:0]     b_q;
    logic [2*WIDTH-1:0]   acc_q, acc_next;
    logic [CNT_W-1:0]     cnt_q;
    logic [WIDTH-1:0]     res_next;
    logic [WIDTH-1:0]     skip_result;
    logic                 accept;
    logic                 skip_calc;
    logic                 is_div;

    assign is_div = (op_e'(op) == DIVU) || (op_e'(op) == REMU);

    // Requests that never enter CALC, and the result they load directly.
    always_comb begin
        skip_calc   = 1'b0;
        skip_result = '0;
`ifdef MDU_DIV_EN
        if (is_div && (b == '0)) begin
            skip_calc   = 1'b1;
            skip_result = (op_e'(op) == DIVU) ? DIV0_QUOT[WIDTH-1:0] : a;
        end
`else
        if (is_div) begin
            skip_calc   = 1'b1;
            skip_result = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        busy    = (state_q != IDLE);
        done    = (state_q == DONE);
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = skip_calc ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // acc holds {high, low}: product accumulator/multiplier for MUL ops,
    // {partial remainder, dividend->quotient} for divide ops.
    logic [WIDTH:0] mul_sum;
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? b_q : {WIDTH{1'b0}})};

`ifdef MDU_DIV_EN
    logic [WIDTH:0] div_shift;
    logic [WIDTH:0] div_diff;
    logic           div_fit;
    assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_fit   = (div_shift >= {1'b0, b_q});
    assign div_diff  = div_shift - {1'b0, b_q};
`endif

    always_comb begin
        acc_next = {mul_sum, acc_q[WIDTH-1:1]};
`ifdef MDU_DIV_EN
        if ((op_q == DIVU) || (op_q == REMU)) begin
            if (div_fit) begin
                acc_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    always_comb begin
        res_next = '0;
        case (op_q)
            MUL:     res_next = acc_next[WIDTH-1:0];
            MULHU:   res_next = acc_next[2*WIDTH-1:WIDTH];
            DIVU:    res_next = acc_next[WIDTH-1:0];
            REMU:    res_next = acc_next[2*WIDTH-1:WIDTH];
            default: res_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q  <= '0;
            b_q    <= '0;
            op_q   <= MUL;
            cnt_q  <= '0;
            result <= '0;
        end else if (accept) begin
            acc_q <= {{WIDTH{1'b0}}, a};
            b_q   <= b;
            op_q  <= op_e'(op);
            cnt_q <= '0;
            if (skip_calc) begin
                result <= skip_result;
            end
        end else if (state_q == CALC) begin
            acc_q <= acc_next;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST) begin
                result <= res_next;
            end
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit against an arithmetic reference model.
// Expectations follow MDU_DIV_EN the same way the RTL build does.
module tb_mul_div_unit;

    localparam int unsigned W = 32;

    logic         clk;
    logic         rst;
    logic         start;
    logic [1:0]   op_i;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         busy;
    logic         done;
    logic [W-1:0] result;

    int checks = 0;
    int errors = 0;

    mul_div_unit #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op_i),
        .a      (a_i),
        .b      (b_i),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] model_result(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        case (o)
            2'd0: return p[W-1:0];
            2'd1: return p[2*W-1:W];
`ifdef MDU_DIV_EN
            2'd2: return (y == 0) ? {W{1'b1}} : x / y;
            default: return (y == 0) ? x : x % y;
`else
            default: return '0;
`endif
        endcase
    endfunction

    function automatic int model_latency(input logic [1:0] o, input logic [W-1:0] y);
        if (o < 2) return W + 1;
`ifdef MDU_DIV_EN
        return (y == 0) ? 1 : W + 1;
`else
        return 1;
`endif
    endfunction

    // Issues one request and reports when done arrived, the result, and whether
    // busy stayed high / done stayed low on every cycle before it.
    task automatic do_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input int inj, output int cyc, output logic [W-1:0] res, output bit seq_ok);
        op_i = o; a_i = x; b_i = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        op_i = 2'($urandom); a_i = $urandom; b_i = $urandom;
        seq_ok = 1'b1;
        cyc = -1;
        res = 'x;
        for (int c = 1; c <= int'(W) + 8; c++) begin
            if (c == inj) begin
                start = 1'b1; op_i = 2'd0; a_i = 9; b_i = 9;
            end
            if (done === 1'b1) begin
                cyc = c;
                res = result;
                if (busy !== 1'b1) seq_ok = 1'b0;
                break;
            end
            if (busy !== 1'b1) seq_ok = 1'b0;
            @(posedge clk); #1;
            if (c == inj) start = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; op_i = '0; a_i = '0; b_i = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b result=%h, required 0 0 0", busy, done, result);
        end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    task automatic test_directed();
        logic [1:0]   ops [6] = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd3, 2'd2};
        logic [W-1:0] as  [6] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd100, 32'd100, 32'd5};
        logic [W-1:0] bs  [6] = '{32'd6, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7, 32'd7, 32'd0};
        logic [W-1:0] fixed [3] = '{32'd42, 32'hFFFFFFFE, 32'h00000001};
        int cyc; logic [W-1:0] res; bit ok; logic [W-1:0] exp;
        for (int i = 0; i < 6; i++) begin
            do_op(ops[i], as[i], bs[i], 0, cyc, res, ok);
            exp = (i < 3) ? fixed[i] : model_result(ops[i], as[i], bs[i]);
            checks++;
            if (res !== exp || cyc != model_latency(ops[i], bs[i]) || !ok) begin
                errors++;
                $display("FAIL directed_%0d: result=%h cycle=%0d seq_ok=%0d, required result=%h cycle=%0d seq_ok=1",
                         i, res, cyc, ok, exp, model_latency(ops[i], bs[i]));
            end
            @(posedge clk); #1;
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || result !== exp) begin
                errors++;
                $display("FAIL directed_after_%0d: busy=%b done=%b result=%h, required 0 0 %h", i, busy, done, result, exp);
            end
        end
        do_op(2'd3, 32'd5, 32'd0, 0, cyc, res, ok);
        exp = model_result(2'd3, 32'd5, 32'd0);
        checks++;
        if (res !== exp || cyc != model_latency(2'd3, 32'd0)) begin
            errors++;
            $display("FAIL remu_div0: result=%h cycle=%0d, required %h cycle=%0d", res, cyc, exp, model_latency(2'd3, 32'd0));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int cyc; logic [W-1:0] res; bit ok; logic [W-1:0] x, y, exp; logic [1:0] o;
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom);
            x = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 255)) : $urandom;
            y = ($urandom_range(0, 4) == 0) ? '0 : (($urandom_range(0, 2) == 0) ? W'($urandom_range(1, 15)) : $urandom);
            exp = model_result(o, x, y);
            do_op(o, x, y, 0, cyc, res, ok);
            checks++;
            if (res !== exp || cyc != model_latency(o, y) || !ok) begin
                errors++;
                $display("FAIL random_%0d op=%0d a=%h b=%h: result=%h cycle=%0d seq_ok=%0d, required %h cycle=%0d",
                         i, o, x, y, res, cyc, ok, exp, model_latency(o, y));
            end
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end
    endtask

    task automatic test_busy_ignore();
        int cyc; logic [W-1:0] res; bit ok;
        do_op(2'd0, 32'd3, 32'd4, 10, cyc, res, ok);
        checks++;
        if (res !== 32'd12 || cyc != int'(W) + 1 || !ok) begin
            errors++;
            $display("FAIL busy_ignore: result=%0d cycle=%0d seq_ok=%0d, required 12 cycle=%0d", res, cyc, ok, W + 1);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_ignore_idle: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        int cyc; logic [W-1:0] res; bit ok;
        do_op(2'd0, 32'd11, 32'd13, 0, cyc, res, ok);
        checks++;
        if (res !== 32'd143 || cyc != int'(W) + 1) begin
            errors++;
            $display("FAIL b2b_first: result=%0d cycle=%0d, required 143 cycle=%0d", res, cyc, W + 1);
        end
        // Start held through the done cycle must not be taken.
        op_i = 2'd1; a_i = 32'h8000_0000; b_i = 32'd6; start = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_start_in_done: busy=%b done=%b, required 0 0", busy, done);
        end
        do_op(2'd1, 32'h8000_0000, 32'd6, 0, cyc, res, ok);
        checks++;
        if (res !== 32'd3 || cyc != int'(W) + 1 || !ok) begin
            errors++;
            $display("FAIL b2b_second: result=%h cycle=%0d seq_ok=%0d, required 3 cycle=%0d", res, cyc, ok, W + 1);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_mid_reset();
        int cyc; logic [W-1:0] res; bit ok; bit saw_done;
`ifdef MDU_DIV_EN
        op_i = 2'd2;
`else
        op_i = 2'd0;
`endif
        a_i = 32'd100; b_i = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
            errors++;
            $display("FAIL mid_reset: busy=%b done=%b result=%h, required 0 0 0", busy, done, result);
        end
        saw_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done !== 1'b0) saw_done = 1'b1;
        end
        rst = 1'b1;
        for (int i = 0; i < int'(W) + 4; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL mid_reset_no_done: activity seen after abort, required none");
        end
        do_op(2'd0, 32'd2, 32'd2, 0, cyc, res, ok);
        checks++;
        if (res !== 32'd4 || cyc != int'(W) + 1 || !ok) begin
            errors++;
            $display("FAIL post_reset_mul: result=%0d cycle=%0d seq_ok=%0d, required 4 cycle=%0d", res, cyc, ok, W + 1);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_busy_ignore();
        test_back_to_back();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand/result width in bits.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request strobe; sampled only in IDLE.
REQ-005 op  input  2  operation: 0 MUL (low product), 1 MULHU (high product, unsigned), 2 DIVU, 3 REMU.
REQ-006 a  input  WIDTH  operand A / dividend, driven from register-file read port RD1.
REQ-007 b  input  WIDTH  operand B / divisor, driven from register-file read port RD2.
REQ-008 busy  output  1  high in every state other than IDLE.
REQ-009 done  output  1  one-cycle pulse when result is valid.
REQ-010 result  output  WIDTH  operation result, bound for register-file write data WD3.

Function
REQ-011 The FSM SHALL have three states: IDLE, CALC, DONE.
REQ-012 In IDLE with start=1, the block SHALL latch a, b and op, clear its iteration counter, and go to CALC.
REQ-013 Inputs a, b and op SHALL be ignored outside the accepting IDLE edge, and start while busy=1 SHALL be ignored.
REQ-014 CALC SHALL perform exactly one iteration per cycle, for WIDTH cycles, then go to DONE.
- Multiply: shift-add, unsigned, into a 2*WIDTH accumulator.
- Divide: restoring, unsigned, producing quotient and remainder.
REQ-015 In DONE, done SHALL be 1 and result valid; the next state SHALL be IDLE.
REQ-016 Latency SHALL be WIDTH+1 cycles from the accepting edge to the cycle with done=1 (33 at default WIDTH).
REQ-017 result SHALL hold its value until the next DONE; done SHALL be 0 in all other states.
REQ-018 Divide by zero (b=0 with DIVU/REMU) SHALL skip CALC and go directly to DONE (done on cycle 1).
- DIVU result: all ones.
- REMU result: the latched a.
REQ-019 MUL SHALL return product[WIDTH-1:0]; MULHU SHALL return product[2*WIDTH-1:WIDTH]; overflow SHALL be discarded silently.
REQ-020 start asserted in the same cycle as done SHALL be ignored; the first acceptable start is in the following IDLE cycle.

Reset
REQ-021 On rst=0, the block SHALL immediately go to IDLE, with busy=0, done=0, result=0, counter=0 and latched operands=0.
REQ-022 Reset mid-operation SHALL abort the calculation without asserting done; after rst=1, the block SHALL accept start on the next edge.

Configuration
REQ-023 Macro MDU_DIV_EN SHALL compile the divider datapath in.
REQ-024 Without MDU_DIV_EN, DIVU/REMU SHALL be accepted, go directly to DONE and return 0 (done on cycle 1), and no divider logic SHALL be synthesised; MUL/MULHU SHALL be unaffected.

Structure
REQ-025 Package mdu_pkg SHALL hold:
- the op enum (MUL, MULHU, DIVU, REMU);
- the state enum (IDLE, CALC, DONE);
- the divide-by-zero quotient constant.
REQ-026 The block SHALL be a single module with no sub-module; FSM, counter and both datapaths live in mul_div_unit.

Verification
REQ-027 MUL, a=7, b=6, start pulse -> busy=1 for 33 cycles; done=1 on cycle 33 with result=42, then busy=0.
REQ-028 MULHU, a=0xFFFFFFFF, b=0xFFFFFFFF -> result=0xFFFFFFFE on cycle 33; MUL with the same operands -> result=0x00000001.
REQ-029 DIVU then REMU, a=100, b=7 (MDU_DIV_EN defined) -> 14 and 2, each on cycle 33; DIVU a=5, b=0 -> 0xFFFFFFFF on cycle 1; REMU a=5, b=0 -> 5 on cycle 1.
REQ-030 MUL 3*4 started, then start with op=MUL, a=9, b=9 at cycle 10 -> second request ignored; result=12 on cycle 33.
REQ-031 rst=0 asserted at cycle 15 of DIVU 100/7 -> busy, done and result are 0 immediately; no done pulse; a new MUL 2*2 -> result 4 on cycle 33.
REQ-032 Build without MDU_DIV_EN: DIVU 100/7 -> result=0 on cycle 1; MUL 7*6 still returns 42.
